alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, width-parametrised ALU for the NPC execute stage, taking over from the single-cycle 32-bit combinational ALU. It extends the 8-op set with unsigned compare, shifts, and an optional iterative multiplier. Operands enter and results leave through valid/ready handshakes, so the stage can stall around multi-cycle ops. Results are registered and held until consumed.

## Interface
- WIDTH, 32, operand/result width; legal range ≥ 2, power of two
- SHW, $clog2(WIDTH), derived localparam: shift-amount width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; high only in IDLE and not in reset
- op  in  4  operation code (see Operation)
- a  in  WIDTH  operand r1
- b  in  WIDTH  operand r2; b[SHW-1:0] is the shift amount
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- overflow  out  1  signed overflow; ADD/SUB only, else 0
- illegal  out  1  op undefined (or compiled out); result forced 0

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a + ~b + 1)
  - 2 NOT a
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLT signed: 1 when (sum_msb XOR overflow) of a−b
  - 7 EQ
  - 8 SLTU
  - 9 SLL
  - 10 SRL
  - 11 SRA (sign fill)
  - 12 MUL: low WIDTH bits of a*b
  - 13–15 illegal
- Compare results are zero-extended 1/0.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
- Arithmetic wraps modulo 2^WIDTH. Internal adder is WIDTH+1 bits; the carry is discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch op, a and b.
    - Non-MUL op: compute and register result/overflow/illegal, go to DONE.
    - MUL: clear accumulator, go to BUSY.
  - BUSY: one shift-add step per cycle, LSB of multiplier first. Counter runs 0..WIDTH−1. After step WIDTH−1, register the product and go to DONE.
  - DONE: out_valid=1; result, overflow and illegal held stable. On out_ready go to IDLE.
- in_valid while not in IDLE: ignored; the producer must hold its inputs.
- Inputs a, b and op may change freely after acceptance; the block uses only latched copies.

## Timing
- Reset: state=IDLE; result=0, overflow=0, illegal=0, out_valid=0, step counter=0. in_ready=0 while rst is high.
- Reset mid-operation (BUSY or DONE): the in-flight op is discarded with no output. IDLE on the next cycle.
- Non-MUL latency: accepted at edge N, out_valid at N+1.
- MUL latency: accepted at edge N, out_valid at N+WIDTH+1.
- Back-to-back throughput: one op per 2 cycles minimum (IDLE→DONE→IDLE).
- out_ready while out_valid=0: no effect.
- out_ready high in the same cycle DONE is entered: takes effect on the following edge. The result is visible for at least one cycle.
- Shift by 0: result = a. Shift amount uses only b[SHW-1:0]; upper bits of b are ignored.
- MUL by 0, or a = all-ones times all-ones: result matches the low WIDTH bits of the true product, no overflow flag.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier is present and op 12 behaves as above.
- ALU_MUL_EN undefined: no multiplier logic and BUSY is unreachable. Op 12 is treated as illegal: single-cycle, result=0, illegal=1.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ALU_ADD … ALU_MUL)
  - FSM state encoding
  - the opcode width constant (4)
- Sub-module alu_mul_iter (WIDTH parameter) holds the multiplier:
  - ports: start, a, b, busy, done, product
  - internals: step counter and accumulator
  - instantiated only under ALU_MUL_EN
- Single-cycle datapath is inline combinational logic feeding the result register.

## Test plan
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, out_valid one cycle after acceptance.
- SUB 0x80000000−1 → 0x7FFFFFFF, overflow=1; SLT 0x80000000,1 → 1; SLTU same operands → 0.
- SRA 0xF0000000 by b=0x24 (uses 4) → 0xFF000000; SLL by 0 → a unchanged.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001, out_valid exactly 33 cycles after acceptance; in_ready=0 throughout.
- Hold out_ready=0 for 5 cycles in DONE → result stable, in_valid ignored; then out_ready=1 → IDLE next cycle.
- Assert rst during BUSY at step 10 → no out_valid, in_ready=1 one cycle after rst drops. Op 14 → result 0, illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, opcode width and FSM encoding shared by the alu_mc slice
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPW-1:0] ALU_NOT  = 4'd2;
  localparam logic [OPW-1:0] ALU_AND  = 4'd3;
  localparam logic [OPW-1:0] ALU_OR   = 4'd4;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd5;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd6;
  localparam logic [OPW-1:0] ALU_EQ   = 4'd7;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd8;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd9;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd10;
  localparam logic [OPW-1:0] ALU_SRA  = 4'd11;
  localparam logic [OPW-1:0] ALU_MUL  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle between the execute stage and alu_mc
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, overflow, illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, only built when ALU_MUL_EN is defined
// done/product are combinational on the last step so the caller registers the product on that edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] addend;

  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      // multiplier LSB first; multiplicand shifts left so only low WIDTH bits survive
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle handshaked ALU; define ALU_MUL_EN to build the iterative multiplier (op 12)
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             illegal_q;
  logic             out_valid_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_ovf;
  logic             nxt_ill;

  logic             is_mul;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

`ifdef ALU_MUL_EN
  logic mul_start;

  assign is_mul    = (bus.op == ALU_MUL);
  assign mul_start = (state == ST_IDLE) && bus.in_valid && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;

  // One shared adder: everything except ADD computes a - b, compares included.
  always_comb begin
    is_sub  = (bus.op != ALU_ADD);
    b_eff   = is_sub ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sh      = bus.b[SHW-1:0];
    nxt_res = '0;
    nxt_ovf = 1'b0;
    nxt_ill = 1'b0;
    case (bus.op)
      ALU_ADD, ALU_SUB: begin
        nxt_res = sum[WIDTH-1:0];
        nxt_ovf = add_ovf;
      end
      ALU_NOT:  nxt_res = ~bus.a;
      ALU_AND:  nxt_res = bus.a & bus.b;
      ALU_OR:   nxt_res = bus.a | bus.b;
      ALU_XOR:  nxt_res = bus.a ^ bus.b;
      ALU_SLT:  nxt_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      ALU_EQ:   nxt_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      ALU_SLTU: nxt_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      ALU_SLL:  nxt_res = bus.a << sh;
      ALU_SRL:  nxt_res = bus.a >> sh;
      ALU_SRA:  nxt_res = WIDTH'($signed(bus.a) >>> sh);
      default:  nxt_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (is_mul) begin
              state <= ST_BUSY;
            end else begin
              result_q    <= nxt_res;
              overflow_q  <= nxt_ovf;
              illegal_q   <= nxt_ill;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (mul_busy && mul_done) begin
            result_q    <= mul_product;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed-vector bench for alu_mc; MUL checks follow whether ALU_MUL_EN is defined
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, waits for acceptance, then scrambles the inputs.
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op = 4'(($urandom % 12));
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.overflow, bus.illegal} !== 3'b000 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b o=%b i=%b r=%h expected 0", bus.out_valid, bus.overflow, bus.illegal, bus.result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t v[18];
    v[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    v[1]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    v[2]  = '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
    v[3]  = '{ALU_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
    v[4]  = '{ALU_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0};
    v[5]  = '{ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
    v[6]  = '{ALU_SLT,  32'h00000005, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    v[7]  = '{ALU_SLTU, 32'h00000005, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    v[8]  = '{ALU_EQ,   32'h00001234, 32'h00001234, 32'h00000001, 1'b0};
    v[9]  = '{ALU_EQ,   32'h00001234, 32'h00001235, 32'h00000000, 1'b0};
    v[10] = '{ALU_NOT,  32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 1'b0};
    v[11] = '{ALU_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0};
    v[12] = '{ALU_OR,   32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    v[13] = '{ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0};
    v[14] = '{ALU_SRA,  32'hF0000000, 32'h00000024, 32'hFF000000, 1'b0};
    v[15] = '{ALU_SLL,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0};
    v[16] = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
    v[17] = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    for (int i = 0; i < 18; i++) begin
      send(v[i].op, v[i].a, v[i].b);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_latency: out_valid got %b expected 1 one cycle after accept", i, bus.out_valid);
      end
      checks++;
      if (bus.result !== v[i].res || bus.overflow !== v[i].ovf || bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_op%0d: got r=%h o=%b i=%b expected r=%h o=%b i=0",
                 i, v[i].op, bus.result, bus.overflow, bus.illegal, v[i].res, v[i].ovf);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[3];
    ops[0] = 4'd13;
    ops[1] = 4'd14;
    ops[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 32'hDEADBEEF, 32'h1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h0 || bus.illegal !== 1'b1 || bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL illegal_op%0d: got v=%b r=%h i=%b o=%b expected v=1 r=0 i=1 o=0",
                 ops[i], bus.out_valid, bus.result, bus.illegal, bus.overflow);
      end
      consume();
    end
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    vec_t v[4];
    v[0] = '{ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    v[1] = '{ALU_MUL, 32'h00001234, 32'h00000000, 32'h00000000, 1'b0};
    v[2] = '{ALU_MUL, 32'h00010000, 32'h00010001, 32'h00010000, 1'b0};
    v[3] = '{ALU_MUL, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      int lat = 1;
      int ready_seen = 0;
      send(v[i].op, v[i].a, v[i].b);
      while (!bus.out_valid && lat < 100) begin
        if (bus.in_ready) ready_seen++;
        tick();
        lat++;
      end
      checks++;
      if (lat !== 33 || ready_seen !== 0) begin
        errors++;
        $display("FAIL mul%0d_timing: latency %0d in_ready_cycles %0d expected 33 and 0", i, lat, ready_seen);
      end
      checks++;
      if (bus.result !== v[i].res || bus.overflow !== 1'b0 || bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL mul%0d_result: got r=%h o=%b i=%b expected r=%h o=0 i=0",
                 i, bus.result, bus.overflow, bus.illegal, v[i].res);
      end
      consume();
    end
`else
    send(ALU_MUL, 32'h7, 32'h6);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0 || bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL mul_disabled: got v=%b r=%h i=%b expected v=1 r=0 i=1", bus.out_valid, bus.result, bus.illegal);
    end
    consume();
`endif
  endtask

  task automatic test_hold();
    int bad = 0;
    send(ALU_ADD, 32'h00000010, 32'h00000020);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op = ALU_SUB;
      bus.a = 32'h1;
      bus.b = 32'h2;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h30 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, expected 0 (result should stay 00000030)", bad);
    end
    bus.in_valid = 1'b0;
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int ok = 0;
    bus.out_ready = 1'b1;
    bus.op = ALU_ADD;
    bus.a = 32'h1;
    bus.b = 32'h1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0 && bus.out_valid === 1'b1 && bus.result === 32'h2) ok++;
      if (i % 2 == 1 && bus.out_valid === 1'b0 && bus.in_ready === 1'b1) ok++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (ok !== 6) begin
      errors++;
      $display("FAIL back_to_back: %0d of 6 cycles as expected (alternating DONE/IDLE)", ok);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
`ifdef ALU_MUL_EN
    send(ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) tick();
`else
    send(ALU_ADD, 32'h5, 32'h5);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_discard: out_valid high %0d cycles expected 0", seen);
    end
    send(ALU_XOR, 32'hA5A5A5A5, 32'hFFFFFFFF);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL reset_mid_recover: got v=%b r=%h expected v=1 r=5a5a5a5a", bus.out_valid, bus.result);
    end
    consume();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 4'd0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    #2;
    test_reset();
    test_vectors();
    test_illegal();
    test_mul();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
